// File: rtl/irst_scan_ctrl.sv
// rtl/irst_scan_ctrl.sv - post-run register-file scan controller with MISR signature
module irst_scan_ctrl #(
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] POLY     = 32'h04C11DB7,
    parameter logic [31:0] SEED     = 32'hFFFFFFFF,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        halt_req,
    input  logic        halt_ack,
    output logic [2:0]  rf_rd_addr,
    input  logic [15:0] rf_rd_data,
    output logic [15:0] irst_reg_data,
    output logic        irst_valid,
    output logic [2:0]  irst_addr,
    output logic [31:0] signature,
    output logic        busy,
    output logic        irst_done,
    output logic        timeout_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HALT = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        halt_req_q, halt_req_d;
    logic        busy_q, busy_d;
    logic        irst_done_q, irst_done_d;
    logic        timeout_err_q, timeout_err_d;
    logic        irst_valid_q, irst_valid_d;
    logic [15:0] irst_reg_data_q, irst_reg_data_d;
    logic [2:0]  irst_addr_q, irst_addr_d;
    logic [31:0] signature_q, signature_d;
    logic [31:0] misr_next;

    assign misr_next = {signature_q[30:0], 1'b0}
                     ^ (signature_q[31] ? POLY : 32'h0)
                     ^ {16'h0, rf_rd_data};

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        halt_req_d      = halt_req_q;
        busy_d          = busy_q;
        irst_done_d     = irst_done_q;
        timeout_err_d   = timeout_err_q;
        irst_valid_d    = 1'b0;
        irst_reg_data_d = irst_reg_data_q;
        irst_addr_d     = irst_addr_q;
        signature_d     = signature_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE re-arms exactly like IDLE so back-to-back scans need no reset
                if (start) begin
                    state_d       = S_HALT;
                    halt_req_d    = 1'b1;
                    busy_d        = 1'b1;
                    signature_d   = SEED;
                    irst_done_d   = 1'b0;
                    timeout_err_d = 1'b0;
                    cnt_d         = 8'd0;
                end
            end
            S_HALT: begin
                if (halt_ack) begin
                    state_d = S_SCAN;
                    idx_d   = 3'd0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d       = S_DONE;
                    timeout_err_d = 1'b1;
                    halt_req_d    = 1'b0;
                    busy_d        = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SCAN: begin
                irst_reg_data_d = rf_rd_data;
                irst_addr_d     = idx_q;
                irst_valid_d    = 1'b1;
                signature_d     = misr_next;
                if (idx_q == LAST_IDX) begin
                    state_d     = S_DONE;
                    halt_req_d  = 1'b0;
                    busy_d      = 1'b0;
                    irst_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= 8'd0;
            idx_q           <= 3'd0;
            halt_req_q      <= 1'b0;
            busy_q          <= 1'b0;
            irst_done_q     <= 1'b0;
            timeout_err_q   <= 1'b0;
            irst_valid_q    <= 1'b0;
            irst_reg_data_q <= 16'h0;
            irst_addr_q     <= 3'd0;
            signature_q     <= 32'h0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            halt_req_q      <= halt_req_d;
            busy_q          <= busy_d;
            irst_done_q     <= irst_done_d;
            timeout_err_q   <= timeout_err_d;
            irst_valid_q    <= irst_valid_d;
            irst_reg_data_q <= irst_reg_data_d;
            irst_addr_q     <= irst_addr_d;
            signature_q     <= signature_d;
        end
    end

    assign rf_rd_addr    = (state_q == S_SCAN) ? idx_q : 3'd0;
    assign halt_req      = halt_req_q;
    assign busy          = busy_q;
    assign irst_done     = irst_done_q;
    assign timeout_err   = timeout_err_q;
    assign irst_valid    = irst_valid_q;
    assign irst_reg_data = irst_reg_data_q;
    assign irst_addr     = irst_addr_q;
    assign signature     = signature_q;

endmodule

// File: tb/tb_irst_scan_ctrl.sv
// tb/tb_irst_scan_ctrl.sv - directed self-checking bench for irst_scan_ctrl
module tb_irst_scan_ctrl;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        halt_req;
    logic        halt_ack = 1'b1;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic [15:0] irst_reg_data;
    logic        irst_valid;
    logic [2:0]  irst_addr;
    logic [31:0] signature;
    logic        busy;
    logic        irst_done;
    logic        timeout_err;

    logic [15:0] regs [8];
    logic [18:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;
    int          valid_cnt = 0;

    always #5 clk = ~clk;

    assign rf_rd_data = regs[rf_rd_addr];

    irst_scan_ctrl #(
        .NUM_REGS(8), .POLY(POLY), .SEED(32'h0), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .irst_reg_data(irst_reg_data), .irst_valid(irst_valid), .irst_addr(irst_addr),
        .signature(signature), .busy(busy), .irst_done(irst_done), .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected signature: fold each register word into the shift-and-xor MISR from a zero seed
    function automatic logic [31:0] misr_model();
        logic [31:0] s = 32'h0;
        for (int k = 0; k < 8; k++)
            s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ {16'h0, regs[k]};
        return s;
    endfunction

    task automatic push_scan();
        for (int k = 0; k < 8; k++) exp_q.push_back({3'(k), regs[k]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!irst_done && !timeout_err && n < 40) begin
            tick();
            n++;
        end
        if (!irst_done && !timeout_err) check({name, "_wait_bound"}, 32'(n), 32'd0);
    endtask

    always @(negedge clk) begin
        logic [18:0] e;
        if (irst_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("stream_unexpected_word", {13'h0, irst_addr, irst_reg_data}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("stream_word", {13'h0, irst_addr, irst_reg_data}, {13'h0, e});
            end
        end
        if (!rst) begin
            check("halt_req_vs_busy", {31'h0, halt_req}, {31'h0, busy});
            if (!busy) check("rf_addr_idle", {29'h0, rf_rd_addr}, 32'h0);
        end
    end

    initial begin
        int base;
        int hcnt;
        int low_cnt;
        for (int k = 0; k < 8; k++) regs[k] = 16'h0;

        tick();
        tick();
        check("rst_outputs", {halt_req, busy, irst_valid, irst_done, timeout_err, rf_rd_addr, irst_addr},
              32'h0);
        check("rst_data", {16'h0, irst_reg_data}, 32'h0);
        check("rst_sig", signature, 32'h0);
        rst = 1'b0;
        tick();

        // 1: R0=1, ack tied high, exact latency
        regs[0] = 16'h0001;
        push_scan();
        base = valid_cnt;
        pulse_start();
        check("t1_busy_after_start", {31'h0, busy}, 32'd1);
        repeat (8) tick();
        check("t1_done_not_yet", {31'h0, irst_done}, 32'd0);
        tick();
        check("t1_done_at_edge9", {31'h0, irst_done}, 32'd1);
        check("t1_last_valid_coincident", {28'h0, irst_valid, irst_addr}, 32'h0000000F);
        check("t1_sig_literal", signature, 32'h00000080);
        check("t1_sig_model", signature, misr_model());
        tick();
        check("t1_valid_count", 32'(valid_cnt - base), 32'd8);
        check("t1_valid_low_after", {31'h0, irst_valid}, 32'd0);

        // 2: all zero, re-armed from DONE
        regs[0] = 16'h0;
        push_scan();
        pulse_start();
        wait_end("t2");
        check("t2_sig", signature, 32'h0);
        check("t2_flags", {29'h0, irst_done, timeout_err, halt_req}, 32'b100);
        tick();

        // 3: ack never arrives
        halt_ack = 1'b0;
        base = valid_cnt;
        hcnt = 0;
        pulse_start();
        while (halt_req && hcnt < 40) begin
            hcnt++;
            tick();
        end
        check("t3_halt_req_cycles", 32'(hcnt), 32'd16);
        check("t3_flags", {29'h0, timeout_err, irst_done, busy}, 32'b100);
        tick();
        check("t3_no_valid", 32'(valid_cnt - base), 32'd0);

        // 4: late ack, ignored start during SCAN
        regs[3] = 16'hA5A5;
        regs[6] = 16'h1234;
        push_scan();
        base = valid_cnt;
        pulse_start();
        repeat (4) tick();
        halt_ack = 1'b1;
        check("t4_timeout_cleared", {31'h0, timeout_err}, 32'd0);
        tick();
        check("t4_no_valid_yet", {31'h0, irst_valid}, 32'd0);
        tick();
        check("t4_first_valid", {28'h0, irst_valid, irst_addr}, 32'h8);
        pulse_start();
        low_cnt = 0;
        for (int i = 0; i < 40 && !irst_done; i++) begin
            if (!halt_req) low_cnt++;
            tick();
        end
        check("t4_halt_req_held", 32'(low_cnt), 32'd0);
        check("t4_done", {30'h0, irst_done, halt_req}, 32'b10);
        check("t4_sig_model", signature, misr_model());
        repeat (3) tick();
        check("t4_valid_count", 32'(valid_cnt - base), 32'd8);
        check("t4_no_restart", {31'h0, busy}, 32'd0);

        // 5: reset on the fourth SCAN cycle, then a clean scan
        push_scan();
        pulse_start();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        check("t5_rst_outputs", {halt_req, busy, irst_valid, irst_done, timeout_err, rf_rd_addr, irst_addr},
              32'h0);
        check("t5_rst_sig", {signature[15:0], irst_reg_data}, 32'h0);
        rst = 1'b0;
        tick();
        base = valid_cnt;
        push_scan();
        pulse_start();
        wait_end("t5");
        check("t5_sig_model", signature, misr_model());
        tick();
        check("t5_valid_count", 32'(valid_cnt - base), 32'd8);

        // 6: back-to-back from DONE, R7=FFFF
        for (int k = 0; k < 8; k++) regs[k] = 16'h0;
        regs[7] = 16'hFFFF;
        push_scan();
        pulse_start();
        check("t6_done_dropped", {31'h0, irst_done}, 32'd0);
        wait_end("t6");
        check("t6_sig_literal", signature, 32'h0000FFFF);
        tick();
        tick();
        check("stream_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
